// File: rtl/rr_arb_pkg.sv
// Shared defaults and output-register state encoding for the round-robin issue arbiter.
package rr_arb_pkg;

    localparam int unsigned NUM_REQ_DEF = 8;
    localparam int unsigned IDX_W_DEF   = $clog2(NUM_REQ_DEF);
    localparam int unsigned DATA_W_DEF  = 32;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: lowest valid index at or above ptr, else lowest valid overall.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned IDX_W   = IDX_W_DEF
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [IDX_W-1:0]   idx_c,
    output logic               any_valid_c
);

    logic             hi_found;
    logic             lo_found;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;

    // Two priority scans in one pass: one restricted to k >= ptr, one unrestricted for wrap-around.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (valid_i[k] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = IDX_W'(k);
            end
            if (valid_i[k] && !hi_found && (IDX_W'(k) >= ptr_i)) begin
                hi_found = 1'b1;
                hi_idx   = IDX_W'(k);
            end
        end
        any_valid_c = lo_found;
        idx_c       = hi_found ? hi_idx : lo_idx;
        grant_c     = lo_found ? (NUM_REQ'(1) << idx_c) : '0;
    end

endmodule

// File: rtl/rr_issue_arbiter.sv
// Round-robin arbiter feeding a one-entry registered output stage with no-bubble reload.
// Optional per-requester burst lock enabled by defining RR_ARB_LOCK_EN.
module rr_issue_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned IDX_W   = IDX_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
`ifdef RR_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]          req_lock_i,
`endif
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [DATA_W-1:0]           out_data_o,
    output logic [IDX_W-1:0]            out_idx_o
);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  data_q, data_d;

    logic               can_load_c;
    logic               accept_c;
    logic [NUM_REQ-1:0] valid_masked_c;
    logic [NUM_REQ-1:0] grant_c;
    logic [IDX_W-1:0]   pick_idx_c;
    logic               any_valid_c;
    logic [IDX_W-1:0]   next_ptr_c;

`ifdef RR_ARB_LOCK_EN
    logic               lock_q, lock_d;
    logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;

    // While a burst is locked only its owner may compete.
    always_comb begin
        valid_masked_c = req_valid_i;
        if (lock_q) begin
            valid_masked_c = req_valid_i & (NUM_REQ'(1) << lock_idx_q);
        end
    end
`else
    assign valid_masked_c = req_valid_i;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .valid_i     (valid_masked_c),
        .ptr_i       (ptr_q),
        .grant_c     (grant_c),
        .idx_c       (pick_idx_c),
        .any_valid_c (any_valid_c)
    );

    assign can_load_c  = (state_q == EMPTY) || out_ready_i;
    assign accept_c    = can_load_c && any_valid_c && !rst;
    assign req_ready_o = (can_load_c && !rst) ? grant_c : '0;
    assign next_ptr_c  = (pick_idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx_c + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        data_d  = data_q;
`ifdef RR_ARB_LOCK_EN
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
`endif
        if (accept_c) begin
            state_d = FULL;
            idx_d   = pick_idx_c;
            data_d  = req_data_i[32'(pick_idx_c) * DATA_W +: DATA_W];
`ifdef RR_ARB_LOCK_EN
            // Pointer moves only on the closing beat of a locked burst.
            if (req_lock_i[pick_idx_c]) begin
                lock_d     = 1'b1;
                lock_idx_d = pick_idx_c;
            end else begin
                lock_d = 1'b0;
                ptr_d  = next_ptr_c;
            end
`else
            ptr_d = next_ptr_c;
`endif
        end else if (out_ready_i) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
`ifdef RR_ARB_LOCK_EN
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
`ifdef RR_ARB_LOCK_EN
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
`endif
        end
    end

    assign out_valid_o = (state_q == FULL);
    assign out_idx_o   = idx_q;
    assign out_data_o  = data_q;

endmodule

// File: tb/tb_rr_issue_arbiter.sv
// Randomized self-checking bench for rr_issue_arbiter against a rotating-priority reference model.
module tb_rr_issue_arbiter;

    localparam int N  = 8;
    localparam int N5 = 5;
    localparam int DW = 32;
`ifdef RR_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_lock = '0;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [DW-1:0]   out_data;
    logic [2:0]      out_idx;

    logic [N5-1:0]    v5 = '0;
    logic [N5*DW-1:0] d5 = '0;
    logic [N5-1:0]    lk5 = '0;
    logic [N5-1:0]    r5;
    logic             ov5;
    logic             ordy5 = 1'b0;
    logic [DW-1:0]    od5;
    logic [2:0]       oi5;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: registered output stage plus rotating pointer.
    logic          m_valid;
    logic [2:0]    m_idx;
    logic [DW-1:0] m_data;
    int            m_ptr;
    bit            m_lock_act;
    int            m_lock_idx;
    logic [N-1:0]  obs_ready, exp_ready;

    always #5 clk = ~clk;

    rr_issue_arbiter #(.NUM_REQ(N), .IDX_W(3), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
`ifdef RR_ARB_LOCK_EN
        .req_lock_i  (req_lock),
`endif
        .req_ready_o (req_ready),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_idx_o   (out_idx)
    );

    rr_issue_arbiter #(.NUM_REQ(N5), .IDX_W(3), .DATA_W(DW)) dut5 (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (v5),
        .req_data_i  (d5),
`ifdef RR_ARB_LOCK_EN
        .req_lock_i  (lk5),
`endif
        .req_ready_o (r5),
        .out_valid_o (ov5),
        .out_ready_i (ordy5),
        .out_data_o  (od5),
        .out_idx_o   (oi5)
    );

    function automatic int model_pick(input logic [N-1:0] v);
        for (int off = 0; off < N; off++) begin
            int k;
            k = (m_ptr + off) % N;
            if (v[k] && (!m_lock_act || k == m_lock_idx)) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid    = 1'b0;
        m_idx      = '0;
        m_data     = '0;
        m_ptr      = 0;
        m_lock_act = 1'b0;
        m_lock_idx = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive one cycle from a negedge, capture ready, advance the model, return at the next negedge.
    task automatic apply_cycle(input logic [N-1:0] v, input logic rdy, input logic [N-1:0] lk);
        int  g;
        bit  can_load;
        req_valid = v;
        out_ready = rdy;
        req_lock  = lk;
        for (int k = 0; k < N; k++) req_data[k*DW +: DW] = $urandom;
        #1;
        obs_ready = req_ready;
        can_load  = !m_valid || rdy;
        g         = model_pick(v);
        exp_ready = '0;
        if (can_load && g >= 0) exp_ready[g] = 1'b1;
        @(posedge clk);
        if (can_load && g >= 0) begin
            m_valid = 1'b1;
            m_idx   = 3'(g);
            m_data  = req_data[g*DW +: DW];
            if (LOCK_EN && lk[g]) begin
                m_lock_act = 1'b1;
                m_lock_idx = g;
            end else begin
                m_lock_act = 1'b0;
                m_ptr      = (g + 1) % N;
            end
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        req_valid = '1;
        #1;
        n_vec++;
        if ({out_valid, out_idx, out_data, req_ready} !== {1'b0, 3'd0, 32'd0, 8'd0}) begin
            n_err++;
            $display("FAIL reset_state: valid=%b idx=%0d data=%h ready=%b, want 0/0/0/0",
                     out_valid, out_idx, out_data, req_ready);
        end
        do_reset();
        apply_cycle(8'b0010_0000, 1'b1, '0);
        apply_cycle(8'b1000_0000, 1'b0, '0);
        n_vec++;
        if (out_valid !== 1'b1 || out_idx !== 3'd5) begin
            n_err++;
            $display("FAIL reset_prefill: valid=%b idx=%0d, want 1/5", out_valid, out_idx);
        end
        // Assert reset asynchronously while FULL and stalled.
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_vec++;
        if ({out_valid, out_idx, req_ready} !== {1'b0, 3'd0, 8'd0}) begin
            n_err++;
            $display("FAIL reset_midfull: valid=%b idx=%0d ready=%b, want 0/0/0", out_valid, out_idx, req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        apply_cycle(8'hFF, 1'b1, '0);
        n_vec++;
        if (out_valid !== 1'b1 || out_idx !== 3'd0 || obs_ready !== 8'h01) begin
            n_err++;
            $display("FAIL reset_regrant: valid=%b idx=%0d ready=%b, want 1/0/00000001", out_valid, out_idx, obs_ready);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            apply_cycle(8'hFF, 1'b1, '0);
            n_vec++;
            if (out_valid !== 1'b1 || out_idx !== 3'(i % 8) || out_data !== m_data) begin
                n_err++;
                $display("FAIL rr_seq[%0d]: valid=%b idx=%0d data=%h, want 1/%0d/%h",
                         i, out_valid, out_idx, out_data, i % 8, m_data);
            end
        end
    endtask

    task automatic test_wrap();
        logic [2:0] exp_seq [3];
        exp_seq = '{3'd0, 3'd2, 3'd0};
        do_reset();
        apply_cycle(8'b0010_0000, 1'b1, '0);
        for (int i = 0; i < 3; i++) begin
            apply_cycle(8'b0000_0101, 1'b1, '0);
            n_vec++;
            if (out_valid !== 1'b1 || out_idx !== exp_seq[i]) begin
                n_err++;
                $display("FAIL wrap[%0d]: valid=%b idx=%0d, want 1/%0d", i, out_valid, out_idx, exp_seq[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] held;
        apply_cycle(8'b0000_1000, 1'b1, '0);
        held = m_data;
        n_vec++;
        if (out_idx !== 3'd3 || out_data !== held) begin
            n_err++;
            $display("FAIL bp_load: idx=%0d data=%h, want 3/%h", out_idx, out_data, held);
        end
        for (int i = 0; i < 5; i++) begin
            apply_cycle(8'($urandom) | 8'h01, 1'b0, '0);
            n_vec++;
            if (obs_ready !== 8'h00 || out_valid !== 1'b1 || out_idx !== 3'd3 || out_data !== held) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: ready=%b valid=%b idx=%0d data=%h, want 0/1/3/%h",
                         i, obs_ready, out_valid, out_idx, out_data, held);
            end
        end
        apply_cycle(8'hFF, 1'b1, '0);
        n_vec++;
        if (obs_ready !== 8'b0001_0000 || out_valid !== 1'b1 || out_idx !== 3'd4 || out_data !== m_data) begin
            n_err++;
            $display("FAIL bp_release: ready=%b valid=%b idx=%0d, want 00010000/1/4", obs_ready, out_valid, out_idx);
        end
    endtask

    task automatic test_lock();
`ifdef RR_ARB_LOCK_EN
        logic [2:0] exp_seq [4];
        logic [N-1:0] lk_seq [4];
        exp_seq = '{3'd2, 3'd2, 3'd2, 3'd5};
        lk_seq  = '{8'h04, 8'h04, 8'h00, 8'h00};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply_cycle(8'b0010_0100, 1'b1, lk_seq[i]);
            n_vec++;
            if (out_valid !== 1'b1 || out_idx !== exp_seq[i] || obs_ready !== exp_ready) begin
                n_err++;
                $display("FAIL lock[%0d]: valid=%b idx=%0d ready=%b, want 1/%0d/%b",
                         i, out_valid, out_idx, obs_ready, exp_seq[i], exp_ready);
            end
        end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] v;
            v = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            apply_cycle(v, ($urandom_range(0, 3) != 0), 8'($urandom & $urandom));
            n_vec++;
            if (obs_ready !== exp_ready || out_valid !== m_valid || out_idx !== m_idx || out_data !== m_data) begin
                n_err++;
                $display("FAIL random[%0d]: ready=%b valid=%b idx=%0d data=%h, want %b/%b/%0d/%h",
                         i, obs_ready, out_valid, out_idx, out_data, exp_ready, m_valid, m_idx, m_data);
            end
        end
    endtask

    task automatic test_non_pow2();
        do_reset();
        v5    = '1;
        ordy5 = 1'b1;
        for (int i = 0; i < 11; i++) begin
            for (int k = 0; k < N5; k++) d5[k*DW +: DW] = 32'(k * 32'h1111_0000 + i);
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            if (ov5 !== 1'b1 || oi5 !== 3'(i % N5) || od5 !== 32'((i % N5) * 32'h1111_0000 + i)) begin
                n_err++;
                $display("FAIL npot[%0d]: valid=%b idx=%0d data=%h, want 1/%0d", i, ov5, oi5, od5, i % N5);
            end
        end
        v5    = '0;
        ordy5 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_wrap();
        test_backpressure();
        test_lock();
        test_random();
        test_non_pow2();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
